// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer for a 3-digit BCD counter: button edge handling, tick
// prescaler, overflow hold, lap snapshot and a scanned single-digit display bus.
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  input  logic [3:0] num2,
  input  logic [3:0] num1,
  input  logic [3:0] num0,
  output logic       cnt_en,
  output logic       cnt_rst_n,
  output logic [2:0] disp_an,
  output logic [3:0] disp_val,
  output logic [2:0] state,
  output logic       full
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_FULL  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          ss_q, clr_q, lap_q;
  logic          ss_e_q, clr_e_q, lap_e_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   snap_q, snap_d;
  logic          cnt_rst_n_q;

  logic          counting;
  logic          terminal;
  logic          at_max;
  logic          do_ss;
  logic          do_lap;
  logic [11:0]   live;
  logic [11:0]   src;

  // Button sampling; the edge itself is registered so it acts one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_q    <= 1'b0;
      clr_q   <= 1'b0;
      lap_q   <= 1'b0;
      ss_e_q  <= 1'b0;
      clr_e_q <= 1'b0;
      lap_e_q <= 1'b0;
    end else begin
      ss_q    <= btn_ss;
      clr_q   <= btn_clr;
      lap_q   <= btn_lap;
      ss_e_q  <= btn_ss & ~ss_q;
      clr_e_q <= btn_clr & ~clr_q;
      lap_e_q <= btn_lap & ~lap_q;
    end
  end

  assign live     = {num2, num1, num0};
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign terminal = counting && (presc_q == PRESC_LAST);
  assign at_max   = (live == 12'h999);
  assign do_ss    = ss_e_q & ~clr_e_q;
  assign do_lap   = lap_e_q & ~clr_e_q & ~ss_e_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    snap_d  = snap_q;
    if (counting) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
    if (clr_e_q) begin
      state_d = S_IDLE;
      presc_d = '0;
      snap_d  = '0;
    end else if (terminal && at_max) begin
      // Holding at 999 instead of wrapping keeps the reading meaningful.
      state_d = S_FULL;
    end else if (do_ss) begin
      case (state_q)
        S_IDLE, S_PAUSE: state_d = S_RUN;
        S_RUN, S_LAP:    state_d = S_PAUSE;
        default:         state_d = state_q;
      endcase
    end else if (do_lap) begin
      case (state_q)
        S_RUN: begin
          state_d = S_LAP;
          snap_d  = live;
        end
        S_LAP:   state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      snap_q      <= '0;
      scan_q      <= '0;
      idx_q       <= 2'd0;
      cnt_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      snap_q      <= snap_d;
      scan_q      <= scan_d;
      idx_q       <= idx_d;
      cnt_rst_n_q <= ~clr_e_q;
    end
  end

  assign src = (state_q == S_LAP) ? snap_q : live;

  always_comb begin
    disp_an  = 3'b001;
    disp_val = src[3:0];
    case (idx_q)
      2'd1: begin
        disp_an  = 3'b010;
        disp_val = src[7:4];
      end
      2'd2: begin
        disp_an  = 3'b100;
        disp_val = src[11:8];
      end
      default: begin
        disp_an  = 3'b001;
        disp_val = src[3:0];
      end
    endcase
  end

  assign cnt_en    = terminal & ~at_max;
  assign cnt_rst_n = cnt_rst_n_q;
  assign state     = state_q;
  assign full      = (state_q == S_FULL);

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: a behavioural counter stands in for bcd_3digit,
// and a cycle-level reference model is compared against every output.
module tb_bcd_stopwatch_ctrl;

  localparam int TICK_DIV = 10;
  localparam int SCAN_DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3, S_FULL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
  logic [3:0] num2, num1, num0;
  logic       cnt_en, cnt_rst_n, full;
  logic [2:0] disp_an, state;
  logic [3:0] disp_val;

  int cnt = 0;
  bit ld = 1'b0;
  int ld_val = 0;
  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
    .num2(num2), .num1(num1), .num0(num0),
    .cnt_en(cnt_en), .cnt_rst_n(cnt_rst_n),
    .disp_an(disp_an), .disp_val(disp_val),
    .state(state), .full(full)
  );

  // Stand-in for the external BCD counter (with a bench-only preload).
  assign num2 = 4'(cnt / 100);
  assign num1 = 4'((cnt / 10) % 10);
  assign num0 = 4'(cnt % 10);

  always @(posedge clk) begin
    if (cnt_rst_n === 1'b0) cnt <= 0;
    else if (ld) cnt <= ld_val;
    else if (cnt_en === 1'b1) cnt <= (cnt + 1) % 1000;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input int v, input logic [2:0] an);
    case (an)
      3'b001:  return v % 10;
      3'b010:  return (v / 10) % 10;
      3'b100:  return v / 100;
      default: return -1;
    endcase
  endfunction

  // Reference model: state, elapsed run time within a tick, count, lap value.
  int ms = 0, mfrac = 0, mcnt = 0, msnap = 0, mcyc = 0;
  bit mpend = 0, mvalid = 0;
  bit pss = 0, pclr = 0, plap = 0, ess = 0, eclr = 0, elap = 0;

  function automatic bit m_en();
    return (ms == S_RUN || ms == S_LAP) && mfrac == TICK_DIV - 1 && mcnt != 999;
  endfunction

  always @(posedge clk) begin
    bit en, ovf;
    int old;
    en  = mvalid && m_en();
    old = mcnt;
    if (mvalid && mpend) mcnt = 0;
    else if (ld) mcnt = ld_val;
    else if (en) mcnt = mcnt + 1;
    if (!rst_n) begin
      ms = S_IDLE; mfrac = 0; msnap = 0; mcyc = 0; mpend = 1;
      pss = 0; pclr = 0; plap = 0; ess = 0; eclr = 0; elap = 0;
      mvalid = 1;
    end else begin
      ovf = (ms == S_RUN || ms == S_LAP) && mfrac == TICK_DIV - 1 && old == 999;
      if (ms == S_RUN || ms == S_LAP) mfrac = (mfrac + 1) % TICK_DIV;
      mpend = eclr;
      if (eclr) begin
        ms = S_IDLE; mfrac = 0; msnap = 0;
      end else if (ovf) begin
        ms = S_FULL;
      end else if (ess) begin
        if (ms == S_IDLE || ms == S_PAUSE) ms = S_RUN;
        else if (ms == S_RUN || ms == S_LAP) ms = S_PAUSE;
      end else if (elap) begin
        if (ms == S_RUN) begin ms = S_LAP; msnap = old; end
        else if (ms == S_LAP) ms = S_RUN;
      end
      ess  = btn_ss  && !pss;
      eclr = btn_clr && !pclr;
      elap = btn_lap && !plap;
      pss = btn_ss; pclr = btn_clr; plap = btn_lap;
      mcyc++;
    end
  end

  always @(negedge clk) begin
    int idx, src, ean;
    if (mvalid) begin
      idx = (mcyc / SCAN_DIV) % 3;
      ean = 1 << idx;
      src = (ms == S_LAP) ? msnap : mcnt;
      chk("sb_state", int'(state), ms);
      chk("sb_full", int'(full), (ms == S_FULL) ? 1 : 0);
      chk("sb_cnt_en", int'(cnt_en), int'(m_en()));
      chk("sb_cnt_rst_n", int'(cnt_rst_n), mpend ? 0 : 1);
      chk("sb_disp_an", int'(disp_an), ean);
      chk("sb_disp_val", int'(disp_val), digit_of(src, 3'(ean)));
      chk("sb_num", cnt, mcnt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish (errors=%0d)", nerr);
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_ss();
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0; cyc(1);
  endtask

  typedef struct {
    bit ss; bit clr; bit lap; int n; int exp_state; int exp_rstn;
  } vec_t;
  localparam int NV = 25;
  vec_t tbl [NV];

  initial begin
    int scan_exp [12];
    int pulses, first, t, bad, old;

    tbl[0]  = '{0, 0, 0, 2, S_IDLE,  1};
    tbl[1]  = '{1, 0, 0, 3, S_RUN,   1};
    tbl[2]  = '{0, 0, 0, 2, S_RUN,   1};
    tbl[3]  = '{0, 0, 1, 2, S_LAP,   1};
    tbl[4]  = '{0, 0, 0, 2, S_LAP,   1};
    tbl[5]  = '{0, 0, 1, 2, S_RUN,   1};
    tbl[6]  = '{0, 0, 0, 2, S_RUN,   1};
    tbl[7]  = '{0, 0, 1, 2, S_LAP,   1};
    tbl[8]  = '{0, 0, 0, 2, S_LAP,   1};
    tbl[9]  = '{1, 0, 0, 2, S_PAUSE, 1};
    tbl[10] = '{0, 0, 0, 2, S_PAUSE, 1};
    tbl[11] = '{0, 0, 1, 2, S_PAUSE, 1};
    tbl[12] = '{0, 0, 0, 2, S_PAUSE, 1};
    tbl[13] = '{1, 0, 0, 2, S_RUN,   1};
    tbl[14] = '{0, 0, 0, 2, S_RUN,   1};
    tbl[15] = '{1, 1, 1, 2, S_IDLE,  0};
    tbl[16] = '{0, 0, 0, 2, S_IDLE,  1};
    tbl[17] = '{0, 1, 0, 2, S_IDLE,  0};
    tbl[18] = '{0, 0, 0, 2, S_IDLE,  1};
    tbl[19] = '{1, 0, 1, 2, S_RUN,   1};
    tbl[20] = '{0, 0, 0, 2, S_RUN,   1};
    tbl[21] = '{1, 0, 1, 2, S_PAUSE, 1};
    tbl[22] = '{0, 0, 0, 2, S_PAUSE, 1};
    tbl[23] = '{0, 1, 0, 2, S_IDLE,  0};
    tbl[24] = '{0, 0, 0, 2, S_IDLE,  1};
    scan_exp = '{1, 1, 1, 1, 2, 2, 2, 2, 4, 4, 4, 4};

    // Reset values
    cyc(2);
    chk("rst_state", int'(state), S_IDLE);
    chk("rst_cnt_rst_n", int'(cnt_rst_n), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_disp_an", int'(disp_an), 1);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("scan%0d", i), int'(disp_an), scan_exp[i]);
      cyc(1);
    end
    chk("rel_cnt_rst_n", int'(cnt_rst_n), 1);

    // State-transition table
    for (int i = 0; i < NV; i++) begin
      btn_ss = tbl[i].ss; btn_clr = tbl[i].clr; btn_lap = tbl[i].lap;
      cyc(tbl[i].n);
      chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].exp_state);
      chk($sformatf("tbl%0d_rstn", i), int'(cnt_rst_n), tbl[i].exp_rstn);
    end

    // First tick and cadence
    btn_ss = 1'b1; cyc(2);
    chk("b_run", int'(state), S_RUN);
    pulses = 0; first = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c == 2) btn_ss = 1'b0;
      if (cnt_en) begin
        pulses++;
        if (first == 0) first = c;
      end
      cyc(1);
    end
    chk("b_first_tick", first, TICK_DIV);
    chk("b_pulses", pulses, 5);
    chk("b_num5", cnt, 5);

    // Pause preserves the fractional tick
    t = 0;
    while (cnt != 12 && t < 200) begin cyc(1); t++; end
    chk("c_reach12", cnt, 12);
    cyc(3);
    press_ss();
    chk("c_paused", int'(state), S_PAUSE);
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      if (cnt_en) pulses++;
      cyc(1);
    end
    chk("c_pause_no_en", pulses, 0);
    chk("c_pause_num", cnt, 12);
    press_ss();
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c < 5 && cnt_en) pulses++;
      if (c == 5) chk("c_en_5th", int'(cnt_en), 1);
      cyc(1);
    end
    chk("c_early_en", pulses, 0);
    chk("c_num13", cnt, 13);
    press_ss();
    chk("c_repause", int'(state), S_PAUSE);

    // Lap snapshot at 027
    ld_val = 27; ld = 1'b1; cyc(1); ld = 1'b0;
    chk("d_load", cnt, 27);
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0; btn_lap = 1'b1; cyc(1); btn_lap = 1'b0; cyc(1);
    chk("d_lap", int'(state), S_LAP);
    cyc(40);
    chk("d_live31", cnt, 31);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (int'(disp_val) != digit_of(27, disp_an)) bad++;
      cyc(1);
    end
    chk("d_snap_disp", bad, 0);
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0; cyc(1);
    chk("d_back_run", int'(state), S_RUN);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (int'(disp_val) != digit_of(cnt, disp_an)) bad++;
      cyc(1);
    end
    chk("d_live_disp", bad, 0);

    // Overflow hold at 999
    press_ss();
    ld_val = 998; ld = 1'b1; cyc(1); ld = 1'b0;
    press_ss();
    t = 0; bad = 0;
    while (full !== 1'b1 && t < 40) begin
      if (cnt_en && cnt == 999) bad++;
      cyc(1); t++;
    end
    chk("e_no_en_999", bad, 0);
    chk("e_full", int'(full), 1);
    chk("e_state_full", int'(state), S_FULL);
    chk("e_num999", cnt, 999);
    press_ss(); cyc(1);
    chk("e_ss_ignored", int'(state), S_FULL);
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0; cyc(2);
    chk("e_lap_ignored", int'(state), S_FULL);
    chk("e_hold999", cnt, 999);
    btn_clr = 1'b1; cyc(2);
    chk("e_clr_idle", int'(state), S_IDLE);
    chk("e_clr_pulse", int'(cnt_rst_n), 0);
    cyc(1);
    chk("e_clr_one_cycle", int'(cnt_rst_n), 1);
    chk("e_num0", cnt, 0);
    btn_clr = 1'b0; cyc(1);

    // Clear landing on a tick cycle
    press_ss();
    t = 0;
    while (!(ms == S_RUN && mfrac == TICK_DIV - 2) && t < 30) begin cyc(1); t++; end
    btn_clr = 1'b1; cyc(1);
    chk("f_en_with_clr", int'(cnt_en), 1);
    old = cnt;
    cyc(1);
    chk("f_inc_kept", cnt, old + 1);
    chk("f_clr_after", int'(cnt_rst_n), 0);
    chk("f_idle", int'(state), S_IDLE);
    cyc(1);
    chk("f_cleared", cnt, 0);
    btn_clr = 1'b0; cyc(1);

    // Reset mid-run
    press_ss(); cyc(5);
    rst_n = 1'b0; cyc(1);
    chk("g_state", int'(state), S_IDLE);
    chk("g_cnt_rst_n", int'(cnt_rst_n), 0);
    chk("g_disp_an", int'(disp_an), 1);
    rst_n = 1'b1; cyc(2);
    chk("g_num0", cnt, 0);

    // Randomized buttons, preloads and resets against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7, 0) == 0) btn_ss = ~btn_ss;
      if ($urandom_range(9, 0) == 0) btn_lap = ~btn_lap;
      if ($urandom_range(39, 0) == 0) btn_clr = ~btn_clr;
      if ($urandom_range(149, 0) == 0) begin
        ld = 1'b1;
        ld_val = ($urandom_range(1, 0) == 1) ? int'($urandom_range(999, 990))
                                             : int'($urandom_range(999, 0));
      end else begin
        ld = 1'b0;
      end
      rst_n = ($urandom_range(999, 0) == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    ld = 1'b0; rst_n = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
